i2c_slave_responder: RTL and testbench
======================================

// Module: i2c_slave_responder
// PURPOSE
// - Synthesizable single-address I2C slave used as the bus-side responder for I2C master controllers.
// - Oversamples SCL/SDA on the system clock. Detects START, repeated START and STOP.
// - Decodes address and R/W. ACKs matching addresses. Captures write bytes, serves read bytes.
// - Reports each byte and each transfer to a user-side interface.
// PARAMETERS
// - I2C_ADDR_WIDTH  7      : slave address width.
// - I2C_DATA_WIDTH  8      : data byte width.
// - SLAVE_ADDR      7'h22  : address acknowledged. Address byte 0x44 = write, 0x45 = read.
// PORTS
// - clk_i        in   1   system clock. The only clock; SCL is treated as data.
// - rst_i        in   1   reset, asynchronous, active-high.
// - scl_i        in   1   I2C clock, wired-AND bus level.
// - sda_i        in   1   I2C data, wired-AND bus level.
// - sda_o        out  1   open-drain drive: 0 pulls low, 1 releases.
// - xfer_start_o out  1   1-cycle pulse when the address matches.
// - op_o         out  1   0 = write, 1 = read. Valid from xfer_start_o until the next match.
// - wr_data_o    out  8   last byte written by the master.
// - wr_valid_o   out  1   1-cycle pulse on each captured write byte.
// - rd_req_o     out  1   1-cycle pulse requesting the next read byte.
// - rd_data_i    in   8   read byte. Must be valid in the rd_req_o cycle.
// - xfer_done_o  out  1   1-cycle pulse on STOP or repeated START ending a matched transfer.
// BEHAVIOUR
// - Synchronisation: scl_i and sda_i each pass through a 2-FF synchroniser. Edges are detected on the synchronised signals.
// - Reset: sda_o=1, all pulses 0, op_o=0, wr_data_o=0, state IDLE.
// - Bus conditions:
//   - START: SDA falls while SCL is high.
//   - STOP: SDA rises while SCL is high.
//   - Both are recognised in every state and take priority over bit processing in the same cycle.
//   - START from any state goes to ADDR and clears the bit counter.
//   - STOP goes to IDLE and releases sda_o.
// - States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
// - Bit sampling: bits are taken on SCL rising edges, MSB first. SDA is changed by the slave only on the cycle after an SCL falling edge.
// - ADDR: after 8 bits, compare bits[7:1] with SLAVE_ADDR.
//   - Match: pulse xfer_start_o, set op_o=bit0, go to ADDR_ACK.
//   - Mismatch: go to IGNORE. Never drive SDA; wait for START or STOP.
// - ADDR_ACK: drive sda_o=0 from the 8th SCL fall to the 9th SCL fall. Then:
//   - op_o=0: go to WR_DATA.
//   - op_o=1: pulse rd_req_o, latch rd_data_i into the shift register, go to RD_DATA.
// - WR_DATA: on the 8th rising edge, set wr_data_o and pulse wr_valid_o. Then go to WR_ACK, which always ACKs, and return to WR_DATA.
// - RD_DATA: drive shift-register bits, MSB first, each held SCL fall to SCL fall. After the 8th fall release SDA and go to RD_ACK.
// - RD_ACK: sample the master's ACK on the 9th SCL rise.
//   - ACK (0): pulse rd_req_o, latch rd_data_i, go to RD_DATA.
//   - NACK (1): go to IGNORE and wait for STOP or START.
// - xfer_done_o pulses when STOP or repeated START arrives while a matched transfer is active.
// - Reset mid-transfer: return immediately to the reset state and release SDA.
// - No clock stretching: SCL is never driven.
// CONFIGURATION
// - I2C_SLV_GLITCH_FILTER_EN: when defined, each synchronised line also passes through a 3-sample majority filter. This adds 1 clk latency and rejects 1-cycle glitches.
// - When undefined, the synchroniser output is used directly. A 1-cycle glitch may then be taken as an edge.
// STRUCTURE
// - Package i2c_slv_pkg holds: i2c_op_t enum {I2C_WR=0, I2C_RD=1}, the state enum, and the width constants.
// - Sub-module i2c_slv_sync (one instance per line) holds the synchroniser, the optional filter, and rise/fall flags.
// - The top level holds the FSM, bit counter and shift register.
// TESTING
// - Write: START, 0x44, bytes 0..31, STOP.
//   - Expect 33 slave ACKs, xfer_start_o once with op_o=0, 32 wr_valid_o pulses with data 0..31, one xfer_done_o.
// - Read: START, 0x45, rd_data_i supplies 100..131, master ACKs 31 bytes and NACKs the last, STOP.
//   - Expect SDA to carry 100..131, 32 rd_req_o pulses, SDA released after the NACK.
// - Alternating: 64 iterations of [repeated START, 0x44, byte 64+i, repeated START, 0x45, read 1 byte with NACK], then STOP.
//   - Expect each write captured correctly, one xfer_done_o per repeated START, and op_o toggling.
// - Mismatch: START, 0x46.
//   - Expect sda_o to stay 1 for the whole transfer and no pulses.
// - Reset mid-byte: assert rst_i during a read bit.
//   - Expect sda_o=1 asynchronously. A following START, 0x44 is acked normally.
// - Glitch (filter enabled): a 1-clk SDA low pulse while SCL is high produces no START.

Source files
------------

// File: rtl/i2c_slv_pkg.sv
// Shared types and constants for the I2C slave responder: op/state enums, widths, default address.
// No logic of its own; a majority helper serves the optional SCL/SDA glitch filter.
package i2c_slv_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int I2C_CNT_W  = 4;
  localparam logic [I2C_ADDR_W-1:0] I2C_SLV_ADDR_DFLT = 7'h22;

  typedef enum logic {
    I2C_WR = 1'b0,
    I2C_RD = 1'b1
  } i2c_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } i2c_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_slv_sync.sv
// Bus-line conditioner: 2-FF synchroniser, optional 3-sample majority (I2C_SLV_GLITCH_FILTER_EN, +1 clk),
// then rise/fall flags. Latency 2 clk (3 with filter); no backpressure, samples every cycle.
module i2c_slv_sync
  import i2c_slv_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_level;

  // Reset to 1 so an idle (released) bus never looks like an edge after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic r_d1;
  logic r_d2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_d1 <= 1'b1;
      r_d2 <= 1'b1;
    end else begin
      r_d1 <= r_sync;
      r_d2 <= r_d1;
    end
  end

  // A single-cycle excursion is present in at most one of the three taps at a time.
  assign w_level = maj3(r_sync, r_d1, r_d2);
`else
  assign w_level = r_sync;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_slave_responder.sv
// Single-address I2C slave: START/STOP detect, address match/ACK, write capture, read serve; SCL is data.
// Pulses lag the bus by the line conditioner delay (I2C_SLV_GLITCH_FILTER_EN adds 1 clk); never stretches SCL.
module i2c_slave_responder
  import i2c_slv_pkg::*;
#(
  parameter int                         I2C_ADDR_WIDTH = I2C_ADDR_W,
  parameter int                         I2C_DATA_WIDTH = I2C_DATA_W,
  parameter logic [I2C_ADDR_WIDTH-1:0]  SLAVE_ADDR     = I2C_SLV_ADDR_DFLT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic                      xfer_start_o,
  output logic                      op_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      wr_valid_o,
  output logic                      rd_req_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  output logic                      xfer_done_o
);

  localparam logic [I2C_CNT_W-1:0] BIT_LAST = I2C_CNT_W'(I2C_DATA_WIDTH - 1);
  localparam logic [I2C_CNT_W-1:0] BIT_ALL  = I2C_CNT_W'(I2C_DATA_WIDTH);

  logic w_scl;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_sda;
  logic w_sda_rise;
  logic w_sda_fall;
  logic w_start;
  logic w_stop;

  i2c_slv_sync u_scl_sync (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_line  (scl_i),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_slv_sync u_sda_sync (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_line  (sda_i),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_state_t                r_state;
  i2c_state_t                w_state_nxt;
  logic [I2C_CNT_W-1:0]      r_cnt;
  logic [I2C_CNT_W-1:0]      w_cnt_nxt;
  logic [I2C_DATA_WIDTH-1:0] r_shift;
  logic [I2C_DATA_WIDTH-1:0] w_shift_nxt;
  logic [I2C_DATA_WIDTH-1:0] w_byte;
  logic                      r_sda;
  logic                      w_sda_nxt;
  i2c_op_t                   r_op;
  i2c_op_t                   w_op_nxt;
  logic [I2C_DATA_WIDTH-1:0] r_wr_data;
  logic [I2C_DATA_WIDTH-1:0] w_wr_data_nxt;
  logic                      r_active;
  logic                      w_active_nxt;
  logic                      w_xfer_start;
  logic                      w_wr_valid;
  logic                      w_rd_req;
  logic                      w_xfer_done;
  logic                      r_xfer_start;
  logic                      r_wr_valid;
  logic                      r_xfer_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_sda        <= 1'b1;
      r_op         <= I2C_WR;
      r_wr_data    <= '0;
      r_active     <= 1'b0;
      r_xfer_start <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_xfer_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_sda        <= w_sda_nxt;
      r_op         <= w_op_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_active     <= w_active_nxt;
      r_xfer_start <= w_xfer_start;
      r_wr_valid   <= w_wr_valid;
      r_xfer_done  <= w_xfer_done;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_sda_nxt     = r_sda;
    w_op_nxt      = r_op;
    w_wr_data_nxt = r_wr_data;
    w_active_nxt  = r_active;
    w_xfer_start  = 1'b0;
    w_wr_valid    = 1'b0;
    w_rd_req      = 1'b0;
    w_xfer_done   = 1'b0;
    w_byte        = {r_shift[I2C_DATA_WIDTH-2:0], w_sda};

    if (w_start || w_stop) begin
      w_xfer_done  = r_active;
      w_active_nxt = 1'b0;
      w_sda_nxt    = 1'b1;
      w_cnt_nxt    = '0;
      w_state_nxt  = w_start ? S_ADDR : S_IDLE;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == BIT_LAST) begin
              w_cnt_nxt = '0;
              if (w_byte[I2C_DATA_WIDTH-1:1] == SLAVE_ADDR) begin
                w_xfer_start = 1'b1;
                w_op_nxt     = i2c_op_t'(w_byte[0]);
                w_active_nxt = 1'b1;
                w_state_nxt  = S_ADDR_ACK;
              end else begin
                w_state_nxt = S_IGNORE;
              end
            end
          end
        end
        // r_cnt 0: waiting for the 8th fall to start the ACK; 1: waiting for the 9th fall to end it.
        S_ADDR_ACK, S_WR_ACK: begin
          if (w_scl_fall) begin
            if (r_cnt == '0) begin
              w_sda_nxt = 1'b0;
              w_cnt_nxt = 1'b1;
            end else begin
              w_sda_nxt = 1'b1;
              w_cnt_nxt = '0;
              if (r_state == S_WR_ACK || r_op == I2C_WR) begin
                w_state_nxt = S_WR_DATA;
              end else begin
                // The 9th fall is also the first data-bit boundary, so drive the MSB right away.
                w_rd_req    = 1'b1;
                w_shift_nxt = {rd_data_i[I2C_DATA_WIDTH-2:0], 1'b0};
                w_sda_nxt   = rd_data_i[I2C_DATA_WIDTH-1];
                w_cnt_nxt   = 1'b1;
                w_state_nxt = S_RD_DATA;
              end
            end
          end
        end
        S_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == BIT_LAST) begin
              w_wr_data_nxt = w_byte;
              w_wr_valid    = 1'b1;
              w_cnt_nxt     = '0;
              w_state_nxt   = S_WR_ACK;
            end
          end
        end
        S_RD_DATA: begin
          if (w_scl_fall) begin
            if (r_cnt == BIT_ALL) begin
              w_sda_nxt   = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_RD_ACK;
            end else begin
              w_sda_nxt   = r_shift[I2C_DATA_WIDTH-1];
              w_shift_nxt = {r_shift[I2C_DATA_WIDTH-2:0], 1'b0};
              w_cnt_nxt   = r_cnt + 1'b1;
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_rd_req    = 1'b1;
              w_shift_nxt = rd_data_i;
              w_cnt_nxt   = '0;
              w_state_nxt = S_RD_DATA;
            end else begin
              w_state_nxt = S_IGNORE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sda_o        = r_sda;
  assign op_o         = r_op;
  assign wr_data_o    = r_wr_data;
  assign xfer_start_o = r_xfer_start;
  assign wr_valid_o   = r_wr_valid;
  assign xfer_done_o  = r_xfer_done;
  assign rd_req_o     = w_rd_req;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master against the responder; write, read, alternating, mismatch, reset.
module tb_i2c_slave_responder;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_o;
  logic       xfer_start_o;
  logic       op_o;
  logic [7:0] wr_data_o;
  logic       wr_valid_o;
  logic       rd_req_o;
  logic [7:0] rd_data_i;
  logic       xfer_done_o;
  logic [7:0] rd_base = 8'd0;
  logic [7:0] rd_idx = 8'd0;
  wire        scl_bus;
  wire        sda_bus;

  int n_checks = 0;
  int n_errors = 0;
  int n_start = 0;
  int n_wrv = 0;
  int n_rdreq = 0;
  int n_done = 0;
  int n_sda_low = 0;
  logic [7:0] wr_q[$];

  assign scl_bus   = m_scl;
  assign sda_bus   = m_sda & sda_o;
  assign rd_data_i = rd_base + rd_idx;

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scl_i        (scl_bus),
    .sda_i        (sda_bus),
    .sda_o        (sda_o),
    .xfer_start_o (xfer_start_o),
    .op_o         (op_o),
    .wr_data_o    (wr_data_o),
    .wr_valid_o   (wr_valid_o),
    .rd_req_o     (rd_req_o),
    .rd_data_i    (rd_data_i),
    .xfer_done_o  (xfer_done_o)
  );

  // Read data source advances after the DUT has latched the requested byte.
  always @(posedge clk) if (rd_req_o) rd_idx <= rd_idx + 8'd1;

  always @(negedge clk) begin
    if (xfer_start_o) n_start++;
    if (wr_valid_o) begin
      n_wrv++;
      wr_q.push_back(wr_data_o);
    end
    if (rd_req_o) n_rdreq++;
    if (xfer_done_o) n_done++;
    if (!sda_o) n_sda_low++;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 90000 cycles, required to finish earlier");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic put_bit(input logic b, input logic glitch);
    m_sda = b; wait_q();
    m_scl = 1'b1; wait_q();
    if (glitch) begin
      m_sda = 1'b0;
      @(negedge clk);
      m_sda = b;
    end
    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = sda_bus;
    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i], glitch && (i == 7));
    get_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         acks;
    int         s0, w0, r0, d0, l0;

    repeat (5) @(negedge clk);
    check("rst_sda", sda_o, 1);
    check("rst_op", op_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_pulses", {xfer_start_o, wr_valid_o, rd_req_o, xfer_done_o}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Write 0..31
    s0 = n_start; w0 = n_wrv; d0 = n_done;
    wr_q.delete();
    acks = 0;
    bus_start();
    write_byte(8'h44, 1'b0, ack);
    if (!ack) acks++;
    for (int i = 0; i < 32; i++) begin
      write_byte(8'(i), 1'b0, ack);
      if (!ack) acks++;
    end
    bus_stop();
    repeat (4) @(negedge clk);
    check("wr_acks", acks, 33);
    check("wr_xfer_start", n_start - s0, 1);
    check("wr_op", op_o, 0);
    check("wr_valid_cnt", n_wrv - w0, 32);
    check("wr_q_size", wr_q.size(), 32);
    for (int i = 0; i < 32 && i < wr_q.size(); i++) check("wr_data", wr_q[i], i);
    check("wr_xfer_done", n_done - d0, 1);

    // Read 100..131, NACK the last
    rd_base = 8'd100 - rd_idx;
    s0 = n_start; r0 = n_rdreq; d0 = n_done;
    bus_start();
    write_byte(8'h45, 1'b0, ack);
    check("rd_addr_ack", ack, 0);
    for (int k = 0; k < 32; k++) begin
      read_byte(k == 31, d);
      check("rd_byte", d, 100 + k);
    end
    check("rd_release", sda_o, 1);
    bus_stop();
    repeat (4) @(negedge clk);
    check("rd_req_cnt", n_rdreq - r0, 32);
    check("rd_op", op_o, 1);
    check("rd_xfer_start", n_start - s0, 1);
    check("rd_xfer_done", n_done - d0, 1);

    // Alternating write/read with repeated STARTs
    rd_base = 8'd128 - rd_idx;
    s0 = n_start; w0 = n_wrv; r0 = n_rdreq; d0 = n_done;
    wr_q.delete();
    for (int i = 0; i < 64; i++) begin
      bus_start();
      write_byte(8'h44, 1'b0, ack);
      check("alt_wr_addr_ack", ack, 0);
      check("alt_op_wr", op_o, 0);
      write_byte(8'(64 + i), 1'b0, ack);
      bus_start();
      write_byte(8'h45, 1'b0, ack);
      check("alt_op_rd", op_o, 1);
      read_byte(1'b1, d);
      check("alt_rd_byte", d, 128 + i);
    end
    bus_stop();
    repeat (4) @(negedge clk);
    check("alt_wr_cnt", n_wrv - w0, 64);
    for (int i = 0; i < 64 && i < wr_q.size(); i++) check("alt_wr_data", wr_q[i], 64 + i);
    check("alt_xfer_start", n_start - s0, 128);
    check("alt_rd_req", n_rdreq - r0, 64);
    check("alt_xfer_done", n_done - d0, 128);

    // Address mismatch
    s0 = n_start; w0 = n_wrv; r0 = n_rdreq; d0 = n_done; l0 = n_sda_low;
    bus_start();
    write_byte(8'h46, 1'b0, ack);
    check("mm_addr_ack", ack, 1);
    write_byte(8'h00, 1'b0, ack);
    check("mm_data_ack", ack, 1);
    bus_stop();
    repeat (4) @(negedge clk);
    check("mm_sda_low", n_sda_low - l0, 0);
    check("mm_pulses", (n_start - s0) + (n_wrv - w0) + (n_rdreq - r0) + (n_done - d0), 0);

`ifdef I2C_SLV_GLITCH_FILTER_EN
    // A 1-clk SDA low pulse during SCL high must not break the transfer
    w0 = n_wrv; d0 = n_done;
    wr_q.delete();
    bus_start();
    write_byte(8'h44, 1'b0, ack);
    write_byte(8'hFF, 1'b1, ack);
    check("gl_ack", ack, 0);
    check("gl_no_done", n_done - d0, 0);
    bus_stop();
    repeat (4) @(negedge clk);
    check("gl_wr_cnt", n_wrv - w0, 1);
    if (wr_q.size() > 0) check("gl_wr_data", wr_q[0], 8'hFF);
`endif

    // Reset in the middle of a read bit
    rd_base = 8'd0 - rd_idx;
    bus_start();
    write_byte(8'h45, 1'b0, ack);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    check("pre_rst_sda", sda_o, 0);
    rst = 1'b1;
    #1;
    check("async_rst_sda", sda_o, 1);
    check("async_rst_op", op_o, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    s0 = n_start; d0 = n_done;
    bus_start();
    write_byte(8'h44, 1'b0, ack);
    check("post_rst_ack", ack, 0);
    check("post_rst_start", n_start - s0, 1);
    bus_stop();
    repeat (4) @(negedge clk);
    check("post_rst_done", n_done - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
